csr_serializer: RTL

//  Holds one CSR-read instruction from dispatch until it reaches the ROB head, so counter reads are non-speculative.

---
 rtl/csr_serializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/csr_serializer.sv
// rtl/csr_serializer.sv - holds one CSR read until ROB head, then reads the counter CSR block and writes back
// Optional macro CSR_ILLEGAL_EN adds wb_illegal for addresses outside the supported counter set.
module csr_serializer #(
  parameter int ROB_TAG_W = 5,
  parameter int PRD_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [11:0]          disp_csr_addr,
  input  logic [ROB_TAG_W-1:0] disp_rob_tag,
  input  logic [PRD_W-1:0]     disp_prd,
  input  logic                 rob_head_valid,
  input  logic [ROB_TAG_W-1:0] rob_head_tag,
  input  logic                 flush,
  output logic [11:0]          csr_imm,
  input  logic [31:0]          csr_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [31:0]          wb_data,
  output logic [PRD_W-1:0]     wb_prd,
  output logic [ROB_TAG_W-1:0] wb_rob_tag
`ifdef CSR_ILLEGAL_EN
  ,
  output logic                 wb_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_HEAD, READ, WB} state_t;

  state_t                 state;
  logic [11:0]            held_addr;
  logic [ROB_TAG_W-1:0]   held_tag;
  logic [PRD_W-1:0]       held_prd;
  logic [31:0]            data_q;
  logic                   valid_q;

`ifdef CSR_ILLEGAL_EN
  logic addr_legal;
  logic illegal_q;

  always_comb begin
    addr_legal = (held_addr == 12'hC00) || (held_addr == 12'hC80) ||
                 (held_addr == 12'hC02) || (held_addr == 12'hC82);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      held_addr <= '0;
      held_tag  <= '0;
      held_prd  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
`ifdef CSR_ILLEGAL_EN
      illegal_q <= 1'b0;
`endif
    end else if (flush) begin
      // The held op is dropped; stale fields are harmless since wb_valid is low.
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (disp_valid) begin
            held_addr <= disp_csr_addr;
            held_tag  <= disp_rob_tag;
            held_prd  <= disp_prd;
            state     <= WAIT_HEAD;
          end
        end
        WAIT_HEAD: begin
          if (rob_head_valid && (rob_head_tag == held_tag))
            state <= READ;
        end
        READ: begin
`ifdef CSR_ILLEGAL_EN
          data_q    <= addr_legal ? csr_rdata : 32'h0;
          illegal_q <= !addr_legal;
`else
          data_q    <= csr_rdata;
`endif
          valid_q   <= 1'b1;
          state     <= WB;
        end
        WB: begin
          if (wb_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush masks both handshakes in the same cycle it is raised.
  assign disp_ready = (state == IDLE) && !flush;
  assign wb_valid   = valid_q && !flush;
  assign csr_imm    = (state == READ) ? held_addr : 12'h000;
  assign wb_data    = data_q;
  assign wb_prd     = held_prd;
  assign wb_rob_tag = held_tag;
`ifdef CSR_ILLEGAL_EN
  assign wb_illegal = illegal_q;
`endif

endmodule
